// File: rtl/llc_lookup_pkg.sv
// Shared encodings and default-configuration widths for the LLC lookup stage.
package llc_lookup_pkg;

    localparam int LLC_WAYS_DEF  = 16;
    localparam int LLC_WORDS_DEF = 4;
    localparam int WAY_W         = $clog2(LLC_WAYS_DEF);
    localparam int WORD_IDX_W    = $clog2(LLC_WORDS_DEF);

    typedef enum logic {
        LLC_LOOKUP = 1'b0,
        LLC_PROBE  = 1'b1
    } llc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_WALK = 2'd2
    } llc_state_e;

endpackage

// File: rtl/llc_lookup_rr_rr_way_picker.sv
// Rotating-priority find-first: first set bit of avail at ptr, ptr+1, ... (mod WAYS).
module rr_way_picker #(
    parameter  int WAYS     = 16,
    localparam int WAY_BITS = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]     avail,
    input  logic [WAY_BITS-1:0] ptr,
    output logic                found,
    output logic [WAY_BITS-1:0] way
);

    // scan from the furthest offset back toward ptr so the nearest available way wins
    always_comb begin
        found = 1'b0;
        way   = '0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (avail[ptr + WAY_BITS'(k)]) begin
                found = 1'b1;
                way   = ptr + WAY_BITS'(k);
            end
        end
    end

endmodule

// File: rtl/llc_lookup_rr.sv
// LLC set lookup: registered hit/empty/evict decision with a lock-aware
// round-robin victim pointer, followed by a serial walk of owned-word IDs.
module llc_lookup_rr
    import llc_lookup_pkg::*;
#(
    parameter  int WAYS           = 16,
    parameter  int WORDS          = 4,
    parameter  int BITS_PER_WORD  = 32,
    parameter  int CACHE_ID_WIDTH = 5,
    parameter  int TAG_WIDTH      = 14,
    parameter  int STATE_WIDTH    = 3,
    parameter  int STATE_I        = 0,
    localparam int WAY_BITS       = $clog2(WAYS),
    localparam int IDX_BITS       = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int CNT_BITS       = $clog2(WORDS) + 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            req_valid,
    output logic                                            req_ready,
    input  logic                                            req_mode,
    input  logic [TAG_WIDTH-1:0]                            req_tag,
    input  logic [WAYS-1:0][TAG_WIDTH-1:0]                  tags_buf,
    input  logic [WAYS-1:0][STATE_WIDTH-1:0]                states_buf,
    input  logic [WAYS-1:0][WORDS-1:0]                      owners_buf,
    input  logic [WAYS-1:0][WORDS-1:0][BITS_PER_WORD-1:0]   lines_buf,
    input  logic [WAYS-1:0]                                 way_lock,
    output logic                                            rsp_valid,
    input  logic                                            rsp_ready,
    output logic                                            tag_hit,
    output logic                                            empty_way_found,
    output logic                                            evict_valid,
    output logic [WAY_BITS-1:0]                             way_hit,
    output logic [WAY_BITS-1:0]                             empty_way,
    output logic [WAY_BITS-1:0]                             evict_way,
    output logic [WORDS-1:0]                                word_mask_owned,
    output logic [CNT_BITS-1:0]                             owned_count,
    output logic                                            own_valid,
    input  logic                                            own_ready,
    output logic [IDX_BITS-1:0]                             own_word,
    output logic [CACHE_ID_WIDTH-1:0]                       own_cache_id,
    output logic                                            own_last
);

    llc_state_e                              state;
    logic [WAY_BITS-1:0]                     rr_ptr;
    logic                                    mode_q;
    logic [WORDS-1:0]                        rem_q;
    logic [WORDS-1:0][CACHE_ID_WIDTH-1:0]    ids_q;

    logic [WAYS-1:0]                         hit_vec, inv_vec;
    logic                                    hit_c, emp_c, evict_c, pick_found;
    logic [WAY_BITS-1:0]                     hit_way_c, emp_way_c, pick_way, vict_way_c;
    logic [WORDS-1:0]                        mask_c;
    logic [WORDS-1:0][CACHE_ID_WIDTH-1:0]    ids_c;
    logic [CNT_BITS-1:0]                     cnt_c;
    logic [IDX_BITS-1:0]                     walk_idx;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign hit_vec[g] = (tags_buf[g] == req_tag) && (states_buf[g] != STATE_WIDTH'(STATE_I));
        assign inv_vec[g] = (states_buf[g] == STATE_WIDTH'(STATE_I));
    end

    // lowest-index priority for hit and empty way; probes never report an empty way
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        emp_c     = 1'b0;
        emp_way_c = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_BITS'(w);
            end
            if (inv_vec[w]) begin
                emp_c     = 1'b1;
                emp_way_c = WAY_BITS'(w);
            end
        end
        if (req_mode == LLC_PROBE) begin
            emp_c     = 1'b0;
            emp_way_c = '0;
        end
    end

    rr_way_picker #(.WAYS(WAYS)) u_picker (
        .avail (~way_lock),
        .ptr   (rr_ptr),
        .found (pick_found),
        .way   (pick_way)
    );

    assign evict_c    = (req_mode == LLC_LOOKUP) && !hit_c && !emp_c && pick_found;
    assign vict_way_c = hit_c ? hit_way_c : pick_way;
    assign mask_c     = (hit_c || evict_c) ? owners_buf[vict_way_c] : '0;

    // owner IDs of the selected line plus their count, captured at accept
    always_comb begin
        cnt_c = '0;
        ids_c = '0;
        for (int i = 0; i < WORDS; i++) begin
            cnt_c = cnt_c + CNT_BITS'(mask_c[i]);
            if (mask_c[i])
                ids_c[i] = lines_buf[vict_way_c][i][CACHE_ID_WIDTH-1:0];
        end
    end

    // current walk entry is the lowest word still pending
    always_comb begin
        walk_idx = '0;
        for (int i = WORDS - 1; i >= 0; i--)
            if (rem_q[i]) walk_idx = IDX_BITS'(i);
    end

    assign own_word     = walk_idx;
    assign own_cache_id = own_valid ? ids_q[walk_idx] : '0;
    assign own_last     = own_valid && ((rem_q & (rem_q - WORDS'(1))) == '0);

    // request/response/walk sequencer with registered result fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            rr_ptr          <= '0;
            mode_q          <= 1'b0;
            rem_q           <= '0;
            ids_q           <= '0;
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            own_valid       <= 1'b0;
            tag_hit         <= 1'b0;
            empty_way_found <= 1'b0;
            evict_valid     <= 1'b0;
            way_hit         <= '0;
            empty_way       <= '0;
            evict_way       <= '0;
            word_mask_owned <= '0;
            owned_count     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    mode_q          <= req_mode;
                    tag_hit         <= hit_c;
                    way_hit         <= hit_way_c;
                    empty_way_found <= emp_c;
                    empty_way       <= emp_way_c;
                    evict_valid     <= evict_c;
                    evict_way       <= evict_c ? pick_way : '0;
                    word_mask_owned <= mask_c;
                    owned_count     <= cnt_c;
                    ids_q           <= ids_c;
                    if (evict_c) rr_ptr <= pick_way + WAY_BITS'(1);
                    rsp_valid       <= 1'b1;
                    req_ready       <= 1'b0;
                    state           <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    if (mode_q == LLC_LOOKUP && word_mask_owned != '0) begin
                        rem_q     <= word_mask_owned;
                        own_valid <= 1'b1;
                        state     <= ST_WALK;
                    end else begin
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_WALK: if (own_ready) begin
                    rem_q <= rem_q & (rem_q - WORDS'(1));
                    if ((rem_q & (rem_q - WORDS'(1))) == '0) begin
                        own_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_llc_lookup_rr.sv
// Randomised bench for llc_lookup_rr with a queue-based reference model.
module tb_llc_lookup_rr;
    import llc_lookup_pkg::*;

    localparam int WAYS = 16, WORDS = 4, BPW = 32, CID_W = 5, TAG_W = 14, ST_W = 3;

    logic clk = 1'b0, rst = 1'b0;
    logic req_valid = 1'b0, req_mode = 1'b0, rsp_ready = 1'b0, own_ready = 1'b0;
    logic req_ready, rsp_valid, tag_hit, empty_way_found, evict_valid, own_valid, own_last;
    logic [TAG_W-1:0]                        req_tag = '0;
    logic [WAYS-1:0][TAG_W-1:0]              tags_buf = '0;
    logic [WAYS-1:0][ST_W-1:0]               states_buf = '0;
    logic [WAYS-1:0][WORDS-1:0]              owners_buf = '0;
    logic [WAYS-1:0][WORDS-1:0][BPW-1:0]     lines_buf = '0;
    logic [WAYS-1:0]                         way_lock = '0;
    logic [3:0] way_hit, empty_way, evict_way;
    logic [3:0] word_mask_owned;
    logic [2:0] owned_count;
    logic [1:0] own_word;
    logic [CID_W-1:0] own_cache_id;

    llc_lookup_rr #(.WAYS(WAYS), .WORDS(WORDS), .BITS_PER_WORD(BPW), .CACHE_ID_WIDTH(CID_W),
                    .TAG_WIDTH(TAG_W), .STATE_WIDTH(ST_W), .STATE_I(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_tag(req_tag), .tags_buf(tags_buf), .states_buf(states_buf), .owners_buf(owners_buf),
        .lines_buf(lines_buf), .way_lock(way_lock), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .tag_hit(tag_hit), .empty_way_found(empty_way_found), .evict_valid(evict_valid),
        .way_hit(way_hit), .empty_way(empty_way), .evict_way(evict_way),
        .word_mask_owned(word_mask_owned), .owned_count(owned_count), .own_valid(own_valid),
        .own_ready(own_ready), .own_word(own_word), .own_cache_id(own_cache_id), .own_last(own_last)
    );

    always #5 clk = ~clk;

    wire [21:0] got_rsp = {tag_hit, way_hit, empty_way_found, empty_way, evict_valid, evict_way,
                           word_mask_owned, owned_count};

    typedef struct { int word; int id; } own_t;

    int total = 0, bad = 0;
    int m_ptr = 0;
    logic e_hit, e_empty, e_ev;
    int e_hway, e_eway, e_evway, e_count;
    logic [3:0] e_mask;
    own_t wq[$];

    // reference: lists of candidates, first element is the answer
    task automatic model_eval(input logic mode);
        int hits[$], emps[$], cands[$];
        int vw;
        for (int w = 0; w < WAYS; w++) begin
            if (tags_buf[w] == req_tag && states_buf[w] != 0) hits.push_back(w);
            if (states_buf[w] == 0) emps.push_back(w);
        end
        for (int k = 0; k < WAYS; k++)
            if (!way_lock[(m_ptr + k) % WAYS]) cands.push_back((m_ptr + k) % WAYS);
        e_hit   = hits.size() > 0;
        e_hway  = e_hit ? hits[0] : 0;
        e_empty = (mode == 1'b0) && emps.size() > 0;
        e_eway  = e_empty ? emps[0] : 0;
        e_ev    = (mode == 1'b0) && !e_hit && !e_empty && cands.size() > 0;
        e_evway = e_ev ? cands[0] : 0;
        vw      = e_hit ? e_hway : e_evway;
        e_mask  = (e_hit || e_ev) ? owners_buf[vw] : 4'd0;
        e_count = $countones(e_mask);
        wq.delete();
        if (mode == 1'b0)
            for (int i = 0; i < WORDS; i++)
                if (e_mask[i]) wq.push_back('{i, int'(lines_buf[vw][i][CID_W-1:0])});
    endtask

    task automatic fill_set(input logic [TAG_W-1:0] t);
        req_tag = t;
        way_lock = '0;
        for (int w = 0; w < WAYS; w++) begin
            tags_buf[w]   = TAG_W'($urandom);
            if (tags_buf[w] == t) tags_buf[w] = t ^ 14'h1;
            states_buf[w] = ST_W'($urandom_range(1, 7));
            owners_buf[w] = WORDS'($urandom);
            for (int i = 0; i < WORDS; i++) lines_buf[w][i] = $urandom;
        end
    endtask

    // one full transaction: accept, optional response stall, owner walk
    task automatic run_lookup(input logic mode, input int stall, input int own_mode, input string nm);
        logic [21:0] exp_rsp;
        int budget;
        model_eval(mode);
        exp_rsp = {e_hit, 4'(e_hway), e_empty, 4'(e_eway), e_ev, 4'(e_evway), e_mask, 3'(e_count)};
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL %s idle_ready got=%b exp=1", nm, req_ready); end
        req_mode = mode; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        if (e_ev) m_ptr = (e_evway + 1) % WAYS;
        for (int c = 0; c <= stall; c++) begin
            rsp_ready = (c == stall);
            total++;
            if ({rsp_valid, req_ready, own_valid} !== 3'b100) begin
                bad++; $display("FAIL %s resp_hs c=%0d got=%b exp=100", nm, c, {rsp_valid, req_ready, own_valid});
            end
            total++;
            if (got_rsp !== exp_rsp) begin
                bad++; $display("FAIL %s rsp_fields c=%0d got=%h exp=%h", nm, c, got_rsp, exp_rsp);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        budget = 0;
        while (wq.size() > 0 && budget < 40) begin
            case (own_mode)
                0: own_ready = 1'b1;
                1: own_ready = budget[0];
                default: own_ready = 1'($urandom_range(0, 1));
            endcase
            total++;
            if ({own_valid, req_ready, rsp_valid, own_word, own_cache_id, own_last} !==
                {3'b100, 2'(wq[0].word), 5'(wq[0].id), wq.size() == 1}) begin
                bad++;
                $display("FAIL %s own_entry got v=%b w=%0d id=%0d last=%b exp w=%0d id=%0d last=%b",
                         nm, own_valid, own_word, own_cache_id, own_last, wq[0].word, wq[0].id, wq.size() == 1);
            end
            @(posedge clk); #1;
            if (own_ready) void'(wq.pop_front());
            budget++;
        end
        own_ready = 1'b0;
        total++;
        if (wq.size() != 0) begin bad++; $display("FAIL %s walk_timeout left=%0d exp=0", nm, wq.size()); end
        total++;
        if ({own_valid, req_ready, rsp_valid} !== 3'b010) begin
            bad++; $display("FAIL %s back_idle got=%b exp=010", nm, {own_valid, req_ready, rsp_valid});
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({got_rsp, rsp_valid, own_valid, own_word, own_cache_id, own_last, req_ready} !== 33'd1) begin
            bad++; $display("FAIL reset_in got=%h exp=1", {got_rsp, rsp_valid, own_valid, own_word, own_cache_id, own_last, req_ready});
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({got_rsp, rsp_valid, own_valid, req_ready} !== 25'd1) begin
            bad++; $display("FAIL reset_out got=%h exp=1", {got_rsp, rsp_valid, own_valid, req_ready});
        end
    endtask

    task automatic test_hit_owned();
        fill_set(14'h1abc);
        tags_buf[5] = 14'h1abc; tags_buf[9] = 14'h1abc;
        owners_buf[5] = 4'b1010;
        lines_buf[5][1][CID_W-1:0] = 5'd3;
        lines_buf[5][3][CID_W-1:0] = 5'd7;
        run_lookup(1'b0, 0, 0, "hit_owned");
        total++;
        if ({tag_hit, way_hit, owned_count} !== {1'b1, 4'd5, 3'd2}) begin
            bad++; $display("FAIL hit_owned way got=%b/%0d/%0d exp=1/5/2", tag_hit, way_hit, owned_count);
        end
    endtask

    task automatic test_empty();
        fill_set(14'h0042);
        states_buf[2] = '0; states_buf[6] = '0;
        run_lookup(1'b0, 0, 0, "empty");
        total++;
        if ({empty_way_found, empty_way, evict_valid, word_mask_owned} !== {1'b1, 4'd2, 1'b0, 4'd0}) begin
            bad++; $display("FAIL empty_way got=%b/%0d/%b/%h exp=1/2/0/0", empty_way_found, empty_way, evict_valid, word_mask_owned);
        end
        run_lookup(1'b1, 1, 0, "probe_empty");
    endtask

    task automatic test_rr_locks();
        fill_set(14'h0777);
        way_lock = 16'h1fff;
        run_lookup(1'b0, 0, 0, "rr_to14");
        total++;
        if (evict_way !== 4'd13) begin bad++; $display("FAIL rr_first got=%0d exp=13", evict_way); end
        way_lock = 16'h4000;
        run_lookup(1'b0, 0, 0, "rr_skip14");
        total++;
        if (evict_way !== 4'd15) begin bad++; $display("FAIL rr_wrap got=%0d exp=15", evict_way); end
        way_lock = 16'h0001;
        run_lookup(1'b0, 0, 0, "rr_skip0");
        total++;
        if (evict_way !== 4'd1) begin bad++; $display("FAIL rr_skip0 got=%0d exp=1", evict_way); end
    endtask

    task automatic test_all_locked();
        fill_set(14'h0123);
        way_lock = '1;
        run_lookup(1'b0, 0, 0, "all_locked");
        way_lock = '0;
        run_lookup(1'b0, 0, 0, "after_locked");
        total++;
        if (evict_way !== 4'd2) begin bad++; $display("FAIL ptr_unchanged got=%0d exp=2", evict_way); end
    endtask

    task automatic test_backpressure();
        fill_set(14'h0321);
        tags_buf[11] = 14'h0321;
        owners_buf[11] = 4'b1111;
        run_lookup(1'b0, 3, 1, "backpressure");
    endtask

    task automatic test_reset_mid_walk();
        fill_set(14'h0555);
        tags_buf[3] = 14'h0555;
        owners_buf[3] = 4'b1101;
        model_eval(1'b0);
        req_mode = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0; own_ready = 1'b1;
        @(posedge clk); #1; own_ready = 1'b0;
        total++;
        if ({own_valid, own_word} !== {1'b1, 2'd2}) begin
            bad++; $display("FAIL midwalk_pos got=%b/%0d exp=1/2", own_valid, own_word);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({own_valid, req_ready, rsp_valid, own_last} !== 4'b0100) begin
            bad++; $display("FAIL midwalk_reset got=%b exp=0100", {own_valid, req_ready, rsp_valid, own_last});
        end
        #1 rst = 1'b1;
        m_ptr = 0;
        @(posedge clk); #1;
        fill_set(14'h0999);
        run_lookup(1'b0, 0, 0, "post_reset");
        total++;
        if ({evict_valid, evict_way} !== {1'b1, 4'd0}) begin
            bad++; $display("FAIL post_reset_ptr got=%b/%0d exp=1/0", evict_valid, evict_way);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            fill_set(TAG_W'($urandom));
            for (int h = $urandom_range(0, 2); h > 0; h--) begin
                int w = $urandom_range(0, WAYS - 1);
                tags_buf[w] = req_tag;
                if ($urandom_range(0, 3) == 0) states_buf[w] = '0;
            end
            if ($urandom_range(0, 2) == 0) states_buf[$urandom_range(0, WAYS - 1)] = '0;
            case ($urandom_range(0, 3))
                0: way_lock = '1;
                1: way_lock = '0;
                default: way_lock = WAYS'($urandom);
            endcase
            run_lookup(1'($urandom_range(0, 1)), $urandom_range(0, 2), 2, "random");
        end
    endtask

    initial begin
        test_reset();
        test_hit_owned();
        test_empty();
        test_rr_locks();
        test_all_locked();
        test_backpressure();
        test_reset_mid_walk();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/llc_lookup_rr.md
Name: llc_lookup_rr

Overview:
- Parametrised, handshaked successor of the LLC hit/miss lookup stage.
- Accepts one set's way buffers and a request tag, then registers hit, empty-way and eviction decisions.
- Picks the eviction victim with an internal round-robin pointer that skips locked ways.
- Serialises the cache IDs of owned words (hit line, or victim line) one per cycle to the recall/invalidate issue logic.
- Sits between the LLC set-buffer read and the LLC request FSM.

Parameters:
- WAYS, 16, ways per set (power of 2, ≥2)
- WORDS, 4, words per line
- BITS_PER_WORD, 32, word width in lines_buf
- CACHE_ID_WIDTH, 5, owner ID width, stored in low bits of each owned word
- TAG_WIDTH, 14, tag width
- STATE_WIDTH, 3, LLC state width
- STATE_I, 0, encoding of the invalid state

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  lookup request
- req_ready  out  1  high only in IDLE
- req_mode  in  1  0=LOOKUP (hit/empty/evict, advances pointer, walks owners); 1=PROBE (hit only, no evict, no walk)
- req_tag  in  TAG_WIDTH  tag to compare
- tags_buf  in  WAYS×TAG_WIDTH  packed per-way tags
- states_buf  in  WAYS×STATE_WIDTH  packed per-way states
- owners_buf  in  WAYS×WORDS  per-way owned-word masks
- lines_buf  in  WAYS×WORDS×BITS_PER_WORD  per-way line data
- way_lock  in  WAYS  ways excluded from eviction
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed
- tag_hit, empty_way_found, evict_valid  out  1 each  registered flags
- way_hit, empty_way, evict_way  out  log2(WAYS) each  registered ways
- word_mask_owned  out  WORDS  owned mask of the hit way or victim way
- owned_count  out  log2(WORDS)+1  popcount of word_mask_owned
- own_valid  out  1  owner stream valid
- own_ready  in  1  owner stream accept
- own_word  out  log2(WORDS)  word index
- own_cache_id  out  CACHE_ID_WIDTH  owner ID
- own_last  out  1  final owner entry

Behaviour:
- Reset values: all outputs 0 except req_ready=1; rr_ptr=0; FSM in IDLE.
- Reset mid-operation: asserting rst at any point aborts RESP/WALK immediately. No partial owner stream resumes after reset.
- FSM states: IDLE, RESP, WALK.
- IDLE → RESP: on req_valid, all inputs are sampled combinationally and the results are registered. rsp_valid rises the next cycle, giving 1-cycle latency.
- Hit: tag match with state != STATE_I. On multiple matches, the lowest index wins.
- Empty way: the lowest index with state == STATE_I. In PROBE mode, empty_way_found is forced to 0.
- Eviction (LOOKUP only, with no hit and no empty way):
  - evict_way is the first way with way_lock=0, searching rr_ptr, rr_ptr+1, … with wrap modulo WAYS.
  - evict_valid=1 and rr_ptr ← evict_way+1 (mod WAYS) on the accept cycle.
  - If every way is locked: evict_valid=0, evict_way=0, and rr_ptr is unchanged.
  - In all other cases evict_valid=0 and rr_ptr is unchanged.
- word_mask_owned:
  - owners_buf[way_hit] on a hit.
  - owners_buf[evict_way] when evict_valid=1.
  - 0 otherwise.
- Owner ID capture: at accept, for each set bit i of word_mask_owned, lines_buf[way][i*BITS_PER_WORD +: CACHE_ID_WIDTH] is captured. Unset words capture 0.
- RESP: outputs are held stable while rsp_valid && !rsp_ready. When rsp_valid && rsp_ready:
  - go to WALK if mode=LOOKUP and word_mask_owned != 0;
  - otherwise go to IDLE.
- WALK:
  - own_valid=1; own_word is the lowest set bit of the remaining mask; own_cache_id is the captured ID for that word.
  - own_last=1 when exactly one bit remains.
  - On own_valid && own_ready, clear that bit. Firing the last entry returns to IDLE.
  - rsp_valid is 0 in WALK. The registered result fields keep their values until the next accept.
- Backpressure: only one request is in flight. req_ready is 0 in RESP and WALK, so no new request is accepted before the walk completes.
- Width rules: rr_ptr wraps naturally because WAYS is a power of 2. owned_count is never truncated (max = WORDS).

Decomposition:
- Package llc_lookup_pkg holds:
  - lookup mode encoding (LLC_LOOKUP=0, LLC_PROBE=1);
  - FSM state enum;
  - derived widths (WAY_W, WORD_IDX_W).
- Sub-module rr_way_picker: combinational rotate-priority find-first over an availability mask. Ports: avail[WAYS], ptr → found, way.

Test Plan:
- Hit with ownership: WAYS=16; way 5 and way 9 both match and are valid → tag_hit=1, way_hit=5. Way 5 has owners_buf=4'b1010 and IDs 3 and 7 at words 1 and 3 → stream (word 1, ID 3, last 0), then (word 3, ID 7, last 1), then back to IDLE.
- Empty way: no hit, ways 2 and 6 invalid → empty_way_found=1, empty_way=2, evict_valid=0, rr_ptr stays 0, no walk.
- Round-robin with locks: all ways valid and missing, rr_ptr=14, way_lock=0x4000 → evict_way=15, rr_ptr=0. Next identical miss with way_lock=0x0001 → evict_way=1.
- All ways locked on a full miss → evict_valid=0, mask 0, rsp then back to IDLE, rr_ptr unchanged.
- Backpressure: hold rsp_ready=0 for 3 cycles, then own_ready toggling 0/1 → outputs stable while stalled, req_ready=0 throughout, each owner emitted exactly once.
- Async reset mid-WALK (second of three owners pending) → own_valid=0 immediately, req_ready=1, rr_ptr=0. The next request proceeds normally.
